rtc_bus_arbiter: RTL and testbench

Sequencer and arbiter for the shared RTC address/data bus. It holds the bus in the init phase for a fixed number of cycles after reset, then grants the bus to the read machine or the write machine. Requesters are the periodic refresh timer, an explicit read request, and the programming-path write request. It drives the one-hot machine-select enables consumed by the PicoBlaze control and global bus machines, and replaces the free-running startup counter and toggle-based read/write select.

---
 rtl/rtc_pkg.sv | 34 +++
 rtl/rtc_refresh_timer.sv | 37 +++
 rtl/rtc_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_rtc_bus_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared encodings for the RTC bus arbiter: FSM state values, one-hot machine
// enables and the default init-phase length.
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  typedef enum logic {
    GR_READ  = 1'b0,
    GR_WRITE = 1'b1
  } grant_e;

  localparam logic [2:0] EN_INIT = 3'b100;
  localparam logic [2:0] EN_WR   = 3'b010;
  localparam logic [2:0] EN_RD   = 3'b001;
  localparam logic [2:0] EN_NONE = 3'b000;

  localparam int unsigned INIT_CYCLES_DEF = 486;

  function automatic logic [2:0] enables_for(state_e st);
    case (st)
      ST_INIT:  return EN_INIT;
      ST_READ:  return EN_RD;
      ST_WRITE: return EN_WR;
      default:  return EN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rtc_refresh_timer.sv
// Wrapping period counter: counts 0..PERIOD-1 while enabled and raises a
// one-cycle expiry pulse on the last count, then wraps to 0.
module rtc_refresh_timer #(
  parameter int unsigned PERIOD = 50000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_d    = cnt_q;
    expire_o = 1'b0;
    if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d    = '0;
        expire_o = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// RTC bus sequencer/arbiter: init phase after reset, then alternating-priority
// read/write grants. Optional grant timeout is enabled by RTC_ARB_TIMEOUT_EN.
module rtc_bus_arbiter
  import rtc_pkg::*;
#(
  parameter int unsigned INIT_CYCLES    = INIT_CYCLES_DEF,
  parameter int unsigned REFRESH_CYCLES = 50000,
  parameter int unsigned TIMEOUT_CYCLES = 2048
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       wr_req_i,
  input  logic       rd_req_i,
  input  logic       done_i,
  output logic [2:0] enables_o,
  output logic       wr_ack_o,
  output logic       rd_done_o,
  output logic       busy_o,
  output logic       timeout_o,
  output logic [2:0] state_o
);

  // One counter serves the init phase and, when enabled, the grant timeout;
  // the two never run at the same time.
  localparam int unsigned CNT_MAX = (INIT_CYCLES > TIMEOUT_CYCLES) ? INIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
`ifdef RTC_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic timeout_q, timeout_d;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_pend_q, rd_pend_d;
  grant_e           last_grant_q, last_grant_d;
  logic [2:0]       enables_q, enables_d;
  logic             busy_q, busy_d;
  logic             wr_ack_q, wr_ack_d;
  logic             rd_done_q, rd_done_d;
  logic             refresh_expire;
  logic             rd_want;

  rtc_refresh_timer #(
    .PERIOD (REFRESH_CYCLES)
  ) u_refresh (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .en_i     (state_q != ST_INIT),
    .expire_o (refresh_expire)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    wr_ack_d     = 1'b0;
    rd_done_d    = 1'b0;
`ifdef RTC_ARB_TIMEOUT_EN
    timeout_d    = timeout_q;
`endif
    // Any number of read triggers before service collapse into one pending read.
    rd_want   = rd_pend_q | rd_req_i | refresh_expire;
    rd_pend_d = rd_want;

    unique case (state_q)
      ST_INIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (wr_req_i && (!rd_want || last_grant_q == GR_READ)) begin
          state_d = ST_WRITE;
        end else if (rd_want) begin
          state_d   = ST_READ;
          rd_pend_d = 1'b0;
        end
      end
      ST_READ, ST_WRITE: begin
        if (done_i) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          if (state_q == ST_READ) begin
            rd_done_d    = 1'b1;
            last_grant_d = GR_READ;
          end else begin
            wr_ack_d     = 1'b1;
            last_grant_d = GR_WRITE;
          end
        end
`ifdef RTC_ARB_TIMEOUT_EN
        // An expired grant completes nothing: no pulse, last_grant unchanged.
        else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = ST_GAP;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase

    enables_d = enables_for(state_d);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      rd_pend_q    <= 1'b0;
      last_grant_q <= GR_READ;
      enables_q    <= EN_INIT;
      busy_q       <= 1'b1;
      wr_ack_q     <= 1'b0;
      rd_done_q    <= 1'b0;
`ifdef RTC_ARB_TIMEOUT_EN
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_pend_q    <= rd_pend_d;
      last_grant_q <= last_grant_d;
      enables_q    <= enables_d;
      busy_q       <= busy_d;
      wr_ack_q     <= wr_ack_d;
      rd_done_q    <= rd_done_d;
`ifdef RTC_ARB_TIMEOUT_EN
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign enables_o = enables_q;
  assign wr_ack_o  = wr_ack_q;
  assign rd_done_o = rd_done_q;
  assign busy_o    = busy_q;
  assign state_o   = state_q;
`ifdef RTC_ARB_TIMEOUT_EN
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Self-checking bench for rtc_bus_arbiter: init phase, write/read grants,
// alternation, reset mid-grant, refresh coalescing and the grant timeout.
module tb_rtc_bus_arbiter;
  import rtc_pkg::*;

  localparam int unsigned INIT_N = 486;
  localparam int unsigned TO_N   = 16;
  localparam int unsigned REF_N  = 100;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Main DUT: default refresh period, short timeout.
  logic       reset_i = 1'b1, wr_req_i = 1'b0, rd_req_i = 1'b0, done_i = 1'b0;
  logic [2:0] enables_o, state_o;
  logic       wr_ack_o, rd_done_o, busy_o, timeout_o;

  // Second DUT: short refresh period, no requesters.
  logic       r_reset = 1'b1, r_wr_req = 1'b0, r_rd_req = 1'b0, r_done = 1'b0;
  logic [2:0] r_enables, r_state;
  logic       r_wr_ack, r_rd_done, r_busy, r_timeout;

  rtc_bus_arbiter #(.INIT_CYCLES(INIT_N), .REFRESH_CYCLES(50000), .TIMEOUT_CYCLES(TO_N)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .wr_req_i(wr_req_i), .rd_req_i(rd_req_i), .done_i(done_i),
    .enables_o(enables_o), .wr_ack_o(wr_ack_o), .rd_done_o(rd_done_o), .busy_o(busy_o),
    .timeout_o(timeout_o), .state_o(state_o));

  rtc_bus_arbiter #(.INIT_CYCLES(INIT_N), .REFRESH_CYCLES(REF_N), .TIMEOUT_CYCLES(2048)) dut_ref (
    .clk_i(clk_i), .reset_i(r_reset), .wr_req_i(r_wr_req), .rd_req_i(r_rd_req), .done_i(r_done),
    .enables_o(r_enables), .wr_ack_o(r_wr_ack), .rd_done_o(r_rd_done), .busy_o(r_busy),
    .timeout_o(r_timeout), .state_o(r_state));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ack_cnt  = 0, rdd_cnt = 0, r_rdd_cnt = 0, r_ack_cnt = 0;
  logic [2:0] exp_q[$];

  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
    if (wr_ack_o)  ack_cnt++;
    if (rd_done_o) rdd_cnt++;
    if (r_rd_done) r_rdd_cnt++;
    if (r_wr_ack)  r_ack_cnt++;
  endtask

  task automatic wait_grant(input int budget, output logic [2:0] en, output int waited);
    waited = 0;
    while (!(enables_o == EN_WR || enables_o == EN_RD) && waited < budget) begin
      tick();
      waited++;
    end
    en = enables_o;
  endtask

  task automatic wait_init(output int cycles);
    cycles = 0;
    while (enables_o == EN_INIT && cycles < int'(INIT_N) + 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic pop_cmp(input string name, input logic [2:0] got);
    logic [2:0] exp;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 3'bxxx;
    n_checks++;
    if (got !== exp) $display("FAIL %s: enables_o=%b expected %b", name, got, exp); else n_pass++;
  endtask

  task automatic test_reset();
    int cycles;
    reset_i = 1'b1;
    repeat (3) tick();
    n_checks++; if (enables_o !== EN_INIT) $display("FAIL rst_enables: got %b expected %b", enables_o, EN_INIT); else n_pass++;
    n_checks++; if (state_o !== 3'd0) $display("FAIL rst_state: got %0d expected 0", state_o); else n_pass++;
    n_checks++; if ({busy_o, wr_ack_o, rd_done_o, timeout_o} !== 4'b1000)
      $display("FAIL rst_flags: busy/ack/rdd/to=%b expected 1000", {busy_o, wr_ack_o, rd_done_o, timeout_o}); else n_pass++;
    reset_i = 1'b0;
    wait_init(cycles);
    n_checks++; if (cycles != int'(INIT_N)) $display("FAIL init_len: %0d cycles expected %0d", cycles, INIT_N); else n_pass++;
    n_checks++; if (state_o !== 3'd1 || enables_o !== EN_NONE || busy_o !== 1'b0)
      $display("FAIL init_exit: state=%0d en=%b busy=%b expected 1/000/0", state_o, enables_o, busy_o); else n_pass++;
    repeat (20) tick();
    n_checks++; if (state_o !== 3'd1) $display("FAIL idle_hold: state=%0d expected 1", state_o); else n_pass++;
  endtask

  task automatic test_write();
    logic [2:0] got;
    int waited, acks0;
    acks0 = ack_cnt;
    wr_req_i = 1'b1;
    exp_q.push_back(EN_WR);
    wait_grant(20, got, waited);
    pop_cmp("wr_grant", got);
    n_checks++; if (waited != 1) $display("FAIL wr_latency: %0d cycles expected 1", waited); else n_pass++;
    repeat (9) tick();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    n_checks++; if (enables_o !== EN_NONE || wr_ack_o !== 1'b1 || state_o !== 3'd4)
      $display("FAIL wr_gap: en=%b ack=%b state=%0d expected 000/1/4", enables_o, wr_ack_o, state_o); else n_pass++;
    wr_req_i = 1'b0;
    repeat (5) tick();
    n_checks++; if (state_o !== 3'd1) $display("FAIL wr_idle: state=%0d expected 1", state_o); else n_pass++;
    n_checks++; if (ack_cnt - acks0 != 1) $display("FAIL wr_ack_count: %0d pulses expected 1", ack_cnt - acks0); else n_pass++;
  endtask

  task automatic test_read();
    logic [2:0] got;
    int waited, rdd0;
    rdd0 = rdd_cnt;
    rd_req_i = 1'b1;
    exp_q.push_back(EN_RD);
    tick();
    rd_req_i = 1'b0;
    wait_grant(20, got, waited);
    pop_cmp("rd_grant", got);
    n_checks++; if (waited != 0) $display("FAIL rd_latency: %0d extra cycles expected 0", waited); else n_pass++;
    repeat (2) tick();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    n_checks++; if (rd_done_o !== 1'b1 || state_o !== 3'd4)
      $display("FAIL rd_gap: rd_done=%b state=%0d expected 1/4", rd_done_o, state_o); else n_pass++;
    repeat (3) tick();
    n_checks++; if (rdd_cnt - rdd0 != 1) $display("FAIL rd_done_count: %0d pulses expected 1", rdd_cnt - rdd0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] got;
    int waited, acks0, rdd0;
    acks0 = ack_cnt;
    rdd0  = rdd_cnt;
    exp_q.push_back(EN_WR);
    exp_q.push_back(EN_RD);
    exp_q.push_back(EN_WR);
    wr_req_i = 1'b1;
    rd_req_i = 1'b1;
    tick();
    rd_req_i = 1'b0;
    wait_grant(20, got, waited);
    pop_cmp("alt_first", got);
    repeat (2) tick();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    if (wr_ack_o) wr_req_i = 1'b0;
    wait_grant(20, got, waited);
    pop_cmp("alt_second", got);
    n_checks++; if (waited != 2) $display("FAIL alt_spacing: gap->grant %0d cycles expected 2", waited); else n_pass++;
    wr_req_i = 1'b1;
    repeat (2) tick();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    wait_grant(20, got, waited);
    pop_cmp("alt_third", got);
    repeat (2) tick();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    if (wr_ack_o) wr_req_i = 1'b0;
    repeat (5) tick();
    n_checks++; if (rdd_cnt - rdd0 != 1) $display("FAIL alt_rd_done: %0d pulses expected 1", rdd_cnt - rdd0); else n_pass++;
    n_checks++; if (ack_cnt - acks0 != 2) $display("FAIL alt_wr_ack: %0d pulses expected 2", ack_cnt - acks0); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL alt_queue: %0d grants never seen expected 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_during_write();
    logic [2:0] got;
    int waited, acks0, cycles;
    acks0 = ack_cnt;
    wr_req_i = 1'b1;
    exp_q.push_back(EN_WR);
    wait_grant(20, got, waited);
    pop_cmp("rstw_grant", got);
    repeat (3) tick();
    reset_i = 1'b1;
    tick();
    n_checks++; if (enables_o !== EN_INIT || state_o !== 3'd0 || wr_ack_o !== 1'b0)
      $display("FAIL rstw_state: en=%b state=%0d ack=%b expected 100/0/0", enables_o, state_o, wr_ack_o); else n_pass++;
    reset_i  = 1'b0;
    wr_req_i = 1'b0;
    wait_init(cycles);
    n_checks++; if (cycles != int'(INIT_N)) $display("FAIL rstw_init_len: %0d cycles expected %0d", cycles, INIT_N); else n_pass++;
    n_checks++; if (ack_cnt != acks0) $display("FAIL rstw_no_ack: %0d pulses expected 0", ack_cnt - acks0); else n_pass++;
  endtask

`ifdef RTC_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [2:0] got;
    int waited, acks0, cycles;
    acks0 = ack_cnt;
    wr_req_i = 1'b1;
    exp_q.push_back(EN_WR);
    exp_q.push_back(EN_WR);
    wait_grant(20, got, waited);
    pop_cmp("to_grant", got);
    cycles = 1;
    while (state_o == 3'd3 && cycles < 100) begin
      tick();
      if (state_o == 3'd3) cycles++;
    end
    n_checks++; if (cycles != int'(TO_N)) $display("FAIL to_len: %0d cycles in WRITE expected %0d", cycles, TO_N); else n_pass++;
    n_checks++; if (timeout_o !== 1'b1 || state_o !== 3'd4)
      $display("FAIL to_flag: timeout=%b state=%0d expected 1/4", timeout_o, state_o); else n_pass++;
    wait_grant(20, got, waited);
    pop_cmp("to_regrant", got);
    n_checks++; if (waited != 2) $display("FAIL to_regrant_gap: %0d cycles expected 2", waited); else n_pass++;
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    wr_req_i = 1'b0;
    repeat (10) tick();
    n_checks++; if (ack_cnt - acks0 != 1) $display("FAIL to_ack: %0d pulses expected 1 (retry only)", ack_cnt - acks0); else n_pass++;
    n_checks++; if (timeout_o !== 1'b1) $display("FAIL to_sticky: timeout=%b expected 1", timeout_o); else n_pass++;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    n_checks++; if (timeout_o !== 1'b0) $display("FAIL to_clear: timeout=%b expected 0", timeout_o); else n_pass++;
  endtask
`else
  task automatic test_timeout();
    logic [2:0] got;
    int waited;
    wr_req_i = 1'b1;
    exp_q.push_back(EN_WR);
    wait_grant(20, got, waited);
    pop_cmp("nto_grant", got);
    repeat (3 * TO_N) tick();
    n_checks++; if (state_o !== 3'd3 || timeout_o !== 1'b0)
      $display("FAIL nto_hold: state=%0d timeout=%b expected 3/0", state_o, timeout_o); else n_pass++;
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    n_checks++; if (wr_ack_o !== 1'b1) $display("FAIL nto_ack: ack=%b expected 1", wr_ack_o); else n_pass++;
    wr_req_i = 1'b0;
    repeat (3) tick();
  endtask
`endif

  task automatic test_refresh();
    int waited, g1, g2, rdd0, acks0;
    r_reset = 1'b1;
    repeat (2) tick();
    r_reset = 1'b0;
    waited = 0;
    while (r_enables == EN_INIT && waited < int'(INIT_N) + 20) begin tick(); waited++; end
    rdd0  = r_rdd_cnt;
    acks0 = r_ack_cnt;
    // First sweep: REF_N cycles after leaving INIT.
    exp_q.push_back(EN_RD);
    waited = 0;
    while (r_enables != EN_RD && waited < 300) begin tick(); waited++; end
    pop_cmp("ref_first", r_enables);
    n_checks++; if (waited != int'(REF_N)) $display("FAIL ref_first_time: %0d cycles expected %0d", waited, REF_N); else n_pass++;
    g1 = cyc;
    repeat (3) tick();
    r_done = 1'b1;
    tick();
    r_done = 1'b0;
    exp_q.push_back(EN_RD);
    waited = 0;
    while (r_enables != EN_RD && waited < 300) begin tick(); waited++; end
    pop_cmp("ref_second", r_enables);
    g2 = cyc;
    n_checks++; if (g2 - g1 != int'(REF_N)) $display("FAIL ref_period: %0d cycles expected %0d", g2 - g1, REF_N); else n_pass++;
    // Hold done for 300 cycles: three expiries collapse into one extra sweep.
    repeat (299) tick();
    n_checks++; if (r_state !== 3'd2 || r_busy !== 1'b1 || r_timeout !== 1'b0)
      $display("FAIL ref_hold: state=%0d busy=%b to=%b expected 2/1/0", r_state, r_busy, r_timeout); else n_pass++;
    r_done = 1'b1;
    tick();
    r_done = 1'b0;
    exp_q.push_back(EN_RD);
    waited = 0;
    while (r_enables != EN_RD && waited < 300) begin tick(); waited++; end
    pop_cmp("ref_coalesced", r_enables);
    n_checks++; if (cyc - g2 != 302) $display("FAIL ref_coalesced_time: %0d cycles expected 302", cyc - g2); else n_pass++;
    repeat (3) tick();
    r_done = 1'b1;
    tick();
    r_done = 1'b0;
    exp_q.push_back(EN_RD);
    waited = 0;
    while (r_enables != EN_RD && waited < 300) begin tick(); waited++; end
    pop_cmp("ref_next", r_enables);
    n_checks++; if (cyc - g2 != 400) $display("FAIL ref_single: next sweep at %0d expected 400", cyc - g2); else n_pass++;
    r_done = 1'b1;
    tick();
    r_done = 1'b0;
    n_checks++; if (r_rdd_cnt - rdd0 != 4 || r_ack_cnt != acks0)
      $display("FAIL ref_pulses: rd_done=%0d wr_ack=%0d expected 4/0", r_rdd_cnt - rdd0, r_ack_cnt - acks0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_during_write();
    test_timeout();
    test_refresh();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
